// File: rtl/conv_weight_mem_pkg.sv
// Shared constants for the conv-layer weight store: bank map and streamer states.
package conv_mem_pkg;
    localparam int BANK_W0    = 0;
    localparam int BANK_W1    = 1;
    localparam int BANK_W2    = 2;
    localparam int BANK_BIAS  = 3;
    localparam int BANK_SHIFT = 4;
    localparam int NUM_BANKS  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;
endpackage

// File: rtl/conv_weight_mem_if.sv
// Config port and filter stream bus of one conv layer's parameter store.
interface conv_weight_mem_if #(
    parameter int BANK_BW   = 3,
    parameter int ADDR_BW   = 3,
    parameter int VECTOR_BW = 104,
    parameter int BIAS_BW   = 32,
    parameter int SHIFT_BW  = 5
);
    logic                 cfg_rd_en_i;
    logic                 cfg_wr_en_i;
    logic [BANK_BW-1:0]   cfg_rd_wr_bank_i;
    logic [ADDR_BW-1:0]   cfg_rd_wr_addr_i;
    logic [VECTOR_BW-1:0] cfg_wr_data_i;
    logic [VECTOR_BW-1:0] cfg_rd_data_o;
    logic                 cfg_err_o;
    logic                 start_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [ADDR_BW-1:0]   filter_idx_o;
    logic [VECTOR_BW-1:0] weight0_o;
    logic [VECTOR_BW-1:0] weight1_o;
    logic [VECTOR_BW-1:0] weight2_o;
    logic [BIAS_BW-1:0]   bias_o;
    logic [SHIFT_BW-1:0]  shift_o;

    modport master (
        output cfg_rd_en_i, cfg_wr_en_i, cfg_rd_wr_bank_i, cfg_rd_wr_addr_i, cfg_wr_data_i,
        output start_i, ready_i,
        input  cfg_rd_data_o, cfg_err_o, busy_o, done_o, valid_o, filter_idx_o,
        input  weight0_o, weight1_o, weight2_o, bias_o, shift_o
    );

    modport slave (
        input  cfg_rd_en_i, cfg_wr_en_i, cfg_rd_wr_bank_i, cfg_rd_wr_addr_i, cfg_wr_data_i,
        input  start_i, ready_i,
        output cfg_rd_data_o, cfg_err_o, busy_o, done_o, valid_o, filter_idx_o,
        output weight0_o, weight1_o, weight2_o, bias_o, shift_o
    );
endinterface

// File: rtl/conv_weight_mem_bank.sv
// Register-file bank: sync write/clear, two combinational read ports
// (one for the config port, one for the filter streamer).
module conv_mem_bank #(
    parameter int ADDR_BW = 3,
    parameter int WIDTH   = 104
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [ADDR_BW-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic [ADDR_BW-1:0] i_rd_a_addr,
    output logic [WIDTH-1:0]   o_rd_a_data,
    input  logic [ADDR_BW-1:0] i_rd_b_addr,
    output logic [WIDTH-1:0]   o_rd_b_data
);
    localparam int DEPTH = 2 ** ADDR_BW;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_a_data = r_mem[i_rd_a_addr];
    assign o_rd_b_data = r_mem[i_rd_b_addr];
endmodule

// File: rtl/conv_weight_mem.sv
// Banked weight/bias/shift store for one conv layer with a start-triggered
// filter streamer (one full filter parameter set per valid/ready beat).
module conv_weight_mem
    import conv_mem_pkg::*;
#(
    parameter int BANK_BW     = 3,
    parameter int ADDR_BW     = 3,
    parameter int NUM_FILTERS = 8,
    parameter int VECTOR_BW   = 104,
    parameter int BIAS_BW     = 32,
    parameter int SHIFT_BW    = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    conv_weight_mem_if.slave bus
);
    localparam logic [ADDR_BW-1:0] LAST_IDX = ADDR_BW'(NUM_FILTERS - 1);
    localparam logic [BANK_BW-1:0] LB_W0    = BANK_BW'(BANK_W0);
    localparam logic [BANK_BW-1:0] LB_W1    = BANK_BW'(BANK_W1);
    localparam logic [BANK_BW-1:0] LB_W2    = BANK_BW'(BANK_W2);
    localparam logic [BANK_BW-1:0] LB_BIAS  = BANK_BW'(BANK_BIAS);
    localparam logic [BANK_BW-1:0] LB_SHIFT = BANK_BW'(BANK_SHIFT);

    state_e                    r_state;
    logic                      r_busy;
    logic                      r_valid;
    logic                      r_done;
    logic                      r_err;
    logic [ADDR_BW-1:0]        r_idx;
    logic [2:0][VECTOR_BW-1:0] r_wt;
    logic [BIAS_BW-1:0]        r_bias;
    logic [SHIFT_BW-1:0]       r_shift;

    logic [NUM_BANKS-1:0]      w_wr_sel;
    logic                      w_wr_drop;
    logic [ADDR_BW-1:0]        w_str_addr;
    logic [2:0][VECTOR_BW-1:0] w_wt_cfg;
    logic [2:0][VECTOR_BW-1:0] w_wt_str;
    logic [BIAS_BW-1:0]        w_bias_cfg;
    logic [BIAS_BW-1:0]        w_bias_str;
    logic [SHIFT_BW-1:0]       w_shift_cfg;
    logic [SHIFT_BW-1:0]       w_shift_str;
    logic [VECTOR_BW-1:0]      w_rd_data;

    // Writes are only accepted while the streamer is idle so a running
    // stream always sees one consistent parameter set.
    always_comb begin
        w_wr_sel = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            w_wr_sel[k] = bus.cfg_wr_en_i && !r_busy && (bus.cfg_rd_wr_bank_i == BANK_BW'(k));
        end
    end

    assign w_wr_drop  = bus.cfg_wr_en_i && r_busy && (bus.cfg_rd_wr_bank_i <= LB_SHIFT);
    assign w_str_addr = (r_state == IDLE) ? '0 : r_idx + 1'b1;

    for (genvar g = 0; g < 3; g++) begin : g_wbank
        conv_mem_bank #(.ADDR_BW(ADDR_BW), .WIDTH(VECTOR_BW)) u_bank (
            .i_clk       (clk_i),
            .i_rst       (rst_i),
            .i_wr_en     (w_wr_sel[g]),
            .i_wr_addr   (bus.cfg_rd_wr_addr_i),
            .i_wr_data   (bus.cfg_wr_data_i),
            .i_rd_a_addr (bus.cfg_rd_wr_addr_i),
            .o_rd_a_data (w_wt_cfg[g]),
            .i_rd_b_addr (w_str_addr),
            .o_rd_b_data (w_wt_str[g])
        );
    end

    conv_mem_bank #(.ADDR_BW(ADDR_BW), .WIDTH(BIAS_BW)) u_bias_bank (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_wr_en     (w_wr_sel[BANK_BIAS]),
        .i_wr_addr   (bus.cfg_rd_wr_addr_i),
        .i_wr_data   (bus.cfg_wr_data_i[BIAS_BW-1:0]),
        .i_rd_a_addr (bus.cfg_rd_wr_addr_i),
        .o_rd_a_data (w_bias_cfg),
        .i_rd_b_addr (w_str_addr),
        .o_rd_b_data (w_bias_str)
    );

    conv_mem_bank #(.ADDR_BW(ADDR_BW), .WIDTH(SHIFT_BW)) u_shift_bank (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_wr_en     (w_wr_sel[BANK_SHIFT]),
        .i_wr_addr   (bus.cfg_rd_wr_addr_i),
        .i_wr_data   (bus.cfg_wr_data_i[SHIFT_BW-1:0]),
        .i_rd_a_addr (bus.cfg_rd_wr_addr_i),
        .o_rd_a_data (w_shift_cfg),
        .i_rd_b_addr ('0),
        .o_rd_b_data (w_shift_str)
    );

    always_comb begin
        w_rd_data = '0;
        if (bus.cfg_rd_en_i) begin
            case (bus.cfg_rd_wr_bank_i)
                LB_W0:    w_rd_data = w_wt_cfg[0];
                LB_W1:    w_rd_data = w_wt_cfg[1];
                LB_W2:    w_rd_data = w_wt_cfg[2];
                LB_BIAS:  w_rd_data = VECTOR_BW'(w_bias_cfg);
                LB_SHIFT: w_rd_data = VECTOR_BW'(w_shift_cfg);
                default:  w_rd_data = '0;
            endcase
        end
    end

    // Streamer: the read port already points at the next filter, so each
    // handshake reloads the output registers and sustains 1 beat/cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wt    <= '0;
            r_bias  <= '0;
            r_shift <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_drop) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_state <= STREAM;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_wt    <= w_wt_str;
                        r_bias  <= w_bias_str;
                        r_shift <= w_shift_str;
                    end
                end
                STREAM: begin
                    if (r_valid && bus.ready_i) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_wt   <= w_wt_str;
                            r_bias <= w_bias_str;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cfg_rd_data_o = w_rd_data;
    assign bus.cfg_err_o     = r_err;
    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.valid_o       = r_valid;
    assign bus.filter_idx_o  = r_idx;
    assign bus.weight0_o     = r_wt[0];
    assign bus.weight1_o     = r_wt[1];
    assign bus.weight2_o     = r_wt[2];
    assign bus.bias_o        = r_bias;
    assign bus.shift_o       = r_shift;
endmodule

// File: tb/tb_conv_weight_mem.sv
// Directed bench for conv_weight_mem: config port, streaming, stalls, errors, reset.
module tb_conv_weight_mem;
    localparam int VB = 104;
    localparam int NF = 8;
    localparam logic [VB-1:0] PAT = 104'h12_3456_789A_BCDE_F00F_1E2D_ABCD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    conv_weight_mem_if bus ();
    conv_weight_mem dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] b, input logic [2:0] a, input logic [VB-1:0] d);
        bus.cfg_wr_en_i      = 1'b1;
        bus.cfg_rd_wr_bank_i = b;
        bus.cfg_rd_wr_addr_i = a;
        bus.cfg_wr_data_i    = d;
        step();
        bus.cfg_wr_en_i = 1'b0;
    endtask

    task automatic rd_setup(input logic [2:0] b, input logic [2:0] a);
        bus.cfg_rd_en_i      = 1'b1;
        bus.cfg_rd_wr_bank_i = b;
        bus.cfg_rd_wr_addr_i = a;
        #1;
    endtask

    function automatic logic [3*VB+37-1:0] exp_beat(input int k);
        logic [31:0] b;
        b = 32'd0 - 32'(k);
        return {VB'(k), VB'(k + 16), VB'(k + 32), b, 5'd7};
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < NF; i++) begin
            cfg_write(3'd0, 3'(i), VB'(i));
            cfg_write(3'd1, 3'(i), VB'(i + 16));
            cfg_write(3'd2, 3'(i), VB'(i + 32));
            cfg_write(3'd3, 3'(i), {72'd0, 32'd0 - 32'(i)});
        end
        cfg_write(3'd4, 3'd0, VB'(7));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_total++;
        if ({bus.busy_o, bus.valid_o, bus.done_o, bus.cfg_err_o} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {bus.busy_o, bus.valid_o, bus.done_o, bus.cfg_err_o});
        else n_pass++;
        n_total++;
        if ({bus.filter_idx_o, bus.weight0_o, bus.weight1_o, bus.weight2_o, bus.bias_o, bus.shift_o} !== '0)
            $display("FAIL reset_data: idx %0d w0 %0h bias %0h shift %0h expected 0", bus.filter_idx_o, bus.weight0_o, bus.bias_o, bus.shift_o);
        else n_pass++;
    endtask

    task automatic test_cfg_rw();
        cfg_write(3'd0, 3'd3, PAT);
        rd_setup(3'd0, 3'd3);
        n_total++;
        if (bus.cfg_rd_data_o !== PAT) $display("FAIL cfg_read_w0: got %0h expected %0h", bus.cfg_rd_data_o, PAT);
        else n_pass++;
        rd_setup(3'd5, 3'd3);
        n_total++;
        if (bus.cfg_rd_data_o !== '0) $display("FAIL cfg_read_bank5: got %0h expected 0", bus.cfg_rd_data_o);
        else n_pass++;
        bus.cfg_rd_en_i = 1'b0;
        bus.cfg_rd_wr_bank_i = 3'd0;
        #1;
        n_total++;
        if (bus.cfg_rd_data_o !== '0) $display("FAIL cfg_read_no_en: got %0h expected 0", bus.cfg_rd_data_o);
        else n_pass++;
        cfg_write(3'd3, 3'd1, {VB{1'b1}});
        cfg_write(3'd4, 3'd1, {VB{1'b1}});
        cfg_write(3'd5, 3'd1, PAT);
        rd_setup(3'd3, 3'd1);
        n_total++;
        if (bus.cfg_rd_data_o !== 104'hFFFF_FFFF) $display("FAIL cfg_bias_zext: got %0h expected ffffffff", bus.cfg_rd_data_o);
        else n_pass++;
        rd_setup(3'd4, 3'd1);
        n_total++;
        if (bus.cfg_rd_data_o !== 104'h1F) $display("FAIL cfg_shift_zext: got %0h expected 1f", bus.cfg_rd_data_o);
        else n_pass++;
        bus.cfg_rd_en_i = 1'b0;
        n_total++;
        if (bus.cfg_err_o !== 1'b0) $display("FAIL cfg_bank5_no_err: got %b expected 0", bus.cfg_err_o);
        else n_pass++;
    endtask

    task automatic test_stream_full();
        load_pattern();
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < NF; k++) begin
            n_total++;
            if ({bus.valid_o, bus.busy_o, bus.done_o, bus.filter_idx_o} !== {3'b110, 3'(k)})
                $display("FAIL full_beat%0d_ctl: got v%b b%b d%b idx%0d expected v1 b1 d0 idx%0d", k, bus.valid_o, bus.busy_o, bus.done_o, bus.filter_idx_o, k);
            else n_pass++;
            n_total++;
            if ({bus.weight0_o, bus.weight1_o, bus.weight2_o, bus.bias_o, bus.shift_o} !== exp_beat(k))
                $display("FAIL full_beat%0d_data: got %0h expected %0h", k, {bus.weight0_o, bus.weight1_o, bus.weight2_o, bus.bias_o, bus.shift_o}, exp_beat(k));
            else n_pass++;
            step();
        end
        n_total++;
        if ({bus.done_o, bus.valid_o, bus.busy_o} !== 3'b101)
            $display("FAIL full_done: got d%b v%b b%b expected d1 v0 b1", bus.done_o, bus.valid_o, bus.busy_o);
        else n_pass++;
        step();
        n_total++;
        if ({bus.done_o, bus.busy_o, bus.weight0_o} !== {2'b00, VB'(7)})
            $display("FAIL full_idle_hold: got d%b b%b w0 %0h expected d0 b0 w0 7", bus.done_o, bus.busy_o, bus.weight0_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back_stall();
        int pat[4] = '{1, 0, 0, 1};
        int e = 0;
        int c = 0;
        bus.ready_i = 1'b0;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        while (e < NF && c < 100) begin
            n_total++;
            if ({bus.valid_o, bus.done_o, bus.filter_idx_o} !== {2'b10, 3'(e)} ||
                {bus.weight0_o, bus.weight1_o, bus.weight2_o, bus.bias_o, bus.shift_o} !== exp_beat(e))
                $display("FAIL stall_c%0d: got v%b d%b idx%0d w0 %0h expected v1 d0 idx%0d w0 %0h", c, bus.valid_o, bus.done_o, bus.filter_idx_o, bus.weight0_o, e, e);
            else n_pass++;
            bus.ready_i = (pat[c % 4] != 0);
            step();
            if (pat[c % 4] != 0) e++;
            c++;
        end
        n_total++;
        if (c >= 100) $display("FAIL stall_timeout: got %0d beats expected %0d", e, NF);
        else n_pass++;
        n_total++;
        if ({bus.done_o, bus.valid_o} !== 2'b10) $display("FAIL stall_done: got d%b v%b expected d1 v0", bus.done_o, bus.valid_o);
        else n_pass++;
        bus.ready_i = 1'b1;
        step();
    endtask

    task automatic test_err();
        bus.ready_i = 1'b0;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        cfg_write(3'd0, 3'd3, VB'(104'hDEAD));
        n_total++;
        if (bus.cfg_err_o !== 1'b1) $display("FAIL err_set: got %b expected 1", bus.cfg_err_o);
        else n_pass++;
        rd_setup(3'd0, 3'd3);
        n_total++;
        if (bus.cfg_rd_data_o !== VB'(3)) $display("FAIL err_mem_kept: got %0h expected 3", bus.cfg_rd_data_o);
        else n_pass++;
        bus.cfg_rd_en_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int k = 0; k < NF + 1; k++) step();
        n_total++;
        if ({bus.busy_o, bus.cfg_err_o} !== 2'b01) $display("FAIL err_sticky: got b%b e%b expected b0 e1", bus.busy_o, bus.cfg_err_o);
        else n_pass++;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        n_total++;
        if ({bus.busy_o, bus.cfg_err_o} !== 2'b10) $display("FAIL err_clear: got b%b e%b expected b1 e0", bus.busy_o, bus.cfg_err_o);
        else n_pass++;
        for (int k = 0; k < NF + 1; k++) step();
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_total++;
        if ({bus.valid_o, bus.filter_idx_o} !== 4'b1100) $display("FAIL rstmid_beat4: got v%b idx%0d expected v1 idx4", bus.valid_o, bus.filter_idx_o);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if ({bus.valid_o, bus.busy_o, bus.done_o, bus.filter_idx_o, bus.weight0_o} !== '0)
            $display("FAIL rstmid_abort: got v%b b%b d%b idx%0d w0 %0h expected all 0", bus.valid_o, bus.busy_o, bus.done_o, bus.filter_idx_o, bus.weight0_o);
        else n_pass++;
        step();
        n_total++;
        if ({bus.done_o, bus.busy_o} !== 2'b00) $display("FAIL rstmid_no_done: got d%b b%b expected 0 0", bus.done_o, bus.busy_o);
        else n_pass++;
        rd_setup(3'd0, 3'd3);
        n_total++;
        if (bus.cfg_rd_data_o !== '0) $display("FAIL rstmid_w0_clear: got %0h expected 0", bus.cfg_rd_data_o);
        else n_pass++;
        rd_setup(3'd3, 3'd5);
        n_total++;
        if (bus.cfg_rd_data_o !== '0) $display("FAIL rstmid_bias_clear: got %0h expected 0", bus.cfg_rd_data_o);
        else n_pass++;
        rd_setup(3'd4, 3'd0);
        n_total++;
        if (bus.cfg_rd_data_o !== '0) $display("FAIL rstmid_shift_clear: got %0h expected 0", bus.cfg_rd_data_o);
        else n_pass++;
        bus.cfg_rd_en_i = 1'b0;
    endtask

    task automatic test_rd_wr_same();
        cfg_write(3'd3, 3'd2, VB'(5));
        bus.cfg_wr_en_i   = 1'b1;
        bus.cfg_wr_data_i = VB'(9);
        rd_setup(3'd3, 3'd2);
        n_total++;
        if (bus.cfg_rd_data_o !== VB'(5)) $display("FAIL rdwr_old: got %0h expected 5", bus.cfg_rd_data_o);
        else n_pass++;
        step();
        bus.cfg_wr_en_i = 1'b0;
        #1;
        n_total++;
        if (bus.cfg_rd_data_o !== VB'(9)) $display("FAIL rdwr_new: got %0h expected 9", bus.cfg_rd_data_o);
        else n_pass++;
        bus.cfg_rd_en_i = 1'b0;
    endtask

    initial begin
        bus.cfg_rd_en_i      = 1'b0;
        bus.cfg_wr_en_i      = 1'b0;
        bus.cfg_rd_wr_bank_i = '0;
        bus.cfg_rd_wr_addr_i = '0;
        bus.cfg_wr_data_i    = '0;
        bus.start_i          = 1'b0;
        bus.ready_i          = 1'b0;
        test_reset();
        test_cfg_rw();
        test_stream_full();
        test_back_to_back_stall();
        test_err();
        test_reset_mid();
        test_rd_wr_same();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/conv_weight_mem.md
Name: conv_weight_mem

Overview:
- Banked weight/bias/shift storage for one convolution layer, sitting directly downstream of the configuration block's per-layer memory port (rd_en/wr_en/bank/addr/wr_data/rd_data).
- Provides zero-latency config reads and one-cycle config writes.
- Provides a start-triggered filter streamer feeding the conv datapath over a valid/ready handshake, one filter's full parameter set per beat.
- One instance per conv layer; conv1 and conv2 differ only by parameters.

Parameters:
- BANK_BW, 3, width of config bank select.
- ADDR_BW, 3, width of filter address; depth = 2**ADDR_BW.
- NUM_FILTERS, 8, filters streamed per start; 1..2**ADDR_BW.
- VECTOR_BW, 104, width of one weight vector (one filter tap row).
- BIAS_BW, 32, bias width; stored in the low bits of the bias bank.
- SHIFT_BW, 5, requantisation shift width; stored in the low bits of shift bank entry 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- cfg_rd_en_i  in  1  config read strobe.
- cfg_wr_en_i  in  1  config write strobe.
- cfg_rd_wr_bank_i  in  BANK_BW  bank: 0..2 weight0..2, 3 bias, 4 shift.
- cfg_rd_wr_addr_i  in  ADDR_BW  filter address within bank.
- cfg_wr_data_i  in  VECTOR_BW  write data.
- cfg_rd_data_o  out  VECTOR_BW  read data, combinational.
- cfg_err_o  out  1  sticky: a config write was dropped while streaming.
- start_i  in  1  begin streaming filters 0..NUM_FILTERS-1.
- busy_o  out  1  streamer not idle.
- done_o  out  1  one-cycle pulse after the final handshake.
- valid_o  out  1  stream beat valid.
- ready_i  in  1  downstream accepts beat.
- filter_idx_o  out  ADDR_BW  index of the presented filter.
- weight0_o, weight1_o, weight2_o  out  VECTOR_BW each  tap rows for the presented filter.
- bias_o  out  BIAS_BW  bias for the presented filter.
- shift_o  out  SHIFT_BW  layer shift (bank 4, address 0).

Behaviour:
- Reset (rst_i=1 at clk edge):
  - All storage cleared to 0.
  - FSM to IDLE.
  - cfg_err_o, busy_o, done_o, valid_o = 0.
  - filter_idx_o, weight*_o, bias_o, shift_o = 0.
  - Reset mid-stream aborts immediately; no done_o pulse.
- Config read:
  - cfg_rd_data_o = mem[bank][addr] in the same cycle cfg_rd_en_i is high.
  - Bias bank is zero-extended from BIAS_BW; shift bank from SHIFT_BW.
  - Output is 0 when cfg_rd_en_i=0 or bank>4.
  - Reads are permitted in any state.
- Config write:
  - mem[bank][addr] <= cfg_wr_data_i at the edge where cfg_wr_en_i=1; visible to reads the next cycle.
  - Bias/shift banks store only the low BIAS_BW/SHIFT_BW bits.
  - bank>4: write ignored, no error.
  - Simultaneous rd+wr to the same entry: read returns the old value (read-before-write).
  - A write while busy_o=1 is dropped and sets cfg_err_o. cfg_err_o clears on the next accepted start_i.
- FSM IDLE -> STREAM -> DONE -> IDLE:
  - IDLE: start_i=1 -> STREAM. idx=0; output registers load filter 0 and shift; valid_o=1 and busy_o=1 from the next cycle.
  - STREAM: outputs hold stable while valid_o&&!ready_i. On valid_o&&ready_i with idx<NUM_FILTERS-1: idx+1 and filter idx+1 is loaded for the next cycle, giving 1 beat/cycle when ready_i is held high. On the handshake with idx=NUM_FILTERS-1: -> DONE, valid_o=0.
  - DONE: done_o=1 for exactly one cycle, busy_o stays 1, -> IDLE.
  - start_i outside IDLE is ignored.
  - Output data registers keep the last beat after the stream ends; only valid_o qualifies them.
- Latency: start_i at cycle N -> first beat at N+1. With ready_i held high, last beat at N+NUM_FILTERS and done_o at N+NUM_FILTERS+1.

Decomposition:
- Package conv_mem_pkg holds:
  - Bank index constants: BANK_W0=0, BANK_W1=1, BANK_W2=2, BANK_BIAS=3, BANK_SHIFT=4.
  - FSM state encoding: IDLE, STREAM, DONE.
- Sub-module conv_mem_bank: a 2**ADDR_BW x width register file with synchronous write, combinational read and synchronous clear. It is instantiated five times, with widths VECTOR_BW x3, BIAS_BW and SHIFT_BW.

Test Plan:
- Write bank0 addr3 = 104'h1234_..._ABCD, then rd_en bank0 addr3 -> cfg_rd_data_o equals the written value in the same cycle as rd_en. Bank 5 read -> 0.
- Load all banks with pattern filter i -> w0=i, w1=i+16, w2=i+32, bias=-i, shift=7. Pulse start with ready_i=1 -> 8 consecutive beats, filter_idx 0..7, matching data, shift_o=7. done_o at start+9.
- Same setup with ready_i toggled 1,0,0,1,... -> no beat lost or duplicated, data stable during stalls, done_o only after idx 7 is accepted.
- Write during STREAM -> memory unchanged (read-back returns the old value), cfg_err_o=1. Next start -> cfg_err_o=0.
- rst_i asserted at beat 4 -> next cycle valid_o=0, busy_o=0, no done_o, all read-backs 0.
- Simultaneous rd+wr to bias addr2 (old=5, new=9) -> read returns 5 that cycle, 9 the next.
